// File: rtl/btn_debounce_repeat.sv
// Button conditioning: 2-flop synchroniser, tick-sampled debounce, edge pulses and
// per-button hold-to-repeat, all registered in the IN_CLK domain.
module btn_debounce_repeat #(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned DEB_TICKS  = 2,
  parameter int unsigned HOLD_TICKS = 50,
  parameter int unsigned RPT_TICKS  = 10
) (
  input  logic       IN_CLK,
  input  logic       IN_RSTN,
  input  logic       IN_ENABLE,
  input  logic [4:0] IN_BTN,
  output logic [4:0] OUT_LEVEL,
  output logic [4:0] OUT_PRESS,
  output logic [4:0] OUT_RELEASE,
  output logic [4:0] OUT_REPEAT,
  output logic       OUT_TICK
);

  localparam int NumBtn = 5;

  localparam logic [23:0] TickLast = 24'(TICK_DIV - 1);
  localparam logic [3:0]  DebLast  = 4'(DEB_TICKS - 1);
  localparam logic [7:0]  HoldLen  = 8'(HOLD_TICKS);
  localparam logic [7:0]  RptLen   = 8'(RPT_TICKS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StRpt  = 2'd2;

  // Tick generator
  logic [23:0] tick_cnt_q, tick_cnt_d;
  logic        tick_q, tick_d;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TickLast) ? 24'd0 : tick_cnt_q + 24'd1;
    // Registered strobe, high exactly while the counter holds TickLast
    tick_d     = (tick_cnt_d == TickLast);
  end

  // Synchroniser
  logic [4:0] sync1_q, sync2_q;

  // Debounce
  logic [3:0] dcnt_q [NumBtn];
  logic [3:0] dcnt_d [NumBtn];
  logic [4:0] level_q, level_d;
  logic [4:0] rise, fall;

  always_comb begin
    level_d = level_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < NumBtn; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          dcnt_d[i] = 4'd0;
        end else if (dcnt_q[i] == DebLast) begin
          level_d[i] = sync2_q[i];
          dcnt_d[i]  = 4'd0;
          rise[i]    = sync2_q[i];
          fall[i]    = ~sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Repeat FSMs, one per button
  logic [1:0] state_q [NumBtn];
  logic [1:0] state_d [NumBtn];
  logic [7:0] hcnt_q  [NumBtn];
  logic [7:0] hcnt_d  [NumBtn];
  logic [7:0] hcnt_inc;
  logic [4:0] fire;

  always_comb begin
    fire     = '0;
    hcnt_inc = '0;
    for (int i = 0; i < NumBtn; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      hcnt_inc   = hcnt_q[i] + 8'd1;
      if (fall[i]) begin
        // Release wins over any repeat due on the same tick
        state_d[i] = StIdle;
        hcnt_d[i]  = 8'd0;
      end else begin
        case (state_q[i])
          StIdle: begin
            if (rise[i]) begin
              state_d[i] = StWait;
              hcnt_d[i]  = 8'd0;
              fire[i]    = 1'b1;
            end
          end
          StWait: begin
            if (tick_q) begin
              if (hcnt_inc == HoldLen) begin
                state_d[i] = StRpt;
                hcnt_d[i]  = 8'd0;
                fire[i]    = 1'b1;
              end else begin
                hcnt_d[i] = hcnt_inc;
              end
            end
          end
          StRpt: begin
            if (tick_q) begin
              if (hcnt_inc == RptLen) begin
                hcnt_d[i] = 8'd0;
                fire[i]   = 1'b1;
              end else begin
                hcnt_d[i] = hcnt_inc;
              end
            end
          end
          default: begin
            state_d[i] = StIdle;
            hcnt_d[i]  = 8'd0;
          end
        endcase
      end
    end
  end

  // Output pulses are masked only; the FSMs keep advancing while disabled
  logic [4:0] press_q, release_q, repeat_q;

  always_ff @(posedge IN_CLK or negedge IN_RSTN) begin
    if (!IN_RSTN) begin
      tick_cnt_q <= 24'd0;
      tick_q     <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        dcnt_q[i]  <= 4'd0;
        state_q[i] <= StIdle;
        hcnt_q[i]  <= 8'd0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      sync1_q    <= IN_BTN;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      press_q    <= rise & {NumBtn{IN_ENABLE}};
      release_q  <= fall & {NumBtn{IN_ENABLE}};
      repeat_q   <= fire & {NumBtn{IN_ENABLE}};
      for (int i = 0; i < NumBtn; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign OUT_LEVEL   = level_q;
  assign OUT_PRESS   = press_q;
  assign OUT_RELEASE = release_q;
  assign OUT_REPEAT  = repeat_q;
  assign OUT_TICK    = tick_q;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench for btn_debounce_repeat: vector table for reset/glitch cases, then
// edge-accurate schedule expectations for hold, simultaneous, enable and mid-hold reset.
module tb_btn_debounce_repeat;

  localparam int TD   = 4;
  localparam int DEB  = 2;
  localparam int HOLD = 5;
  localparam int RPT  = 2;

  logic       IN_CLK;
  logic       IN_RSTN;
  logic       IN_ENABLE;
  logic [4:0] IN_BTN;
  logic [4:0] OUT_LEVEL, OUT_PRESS, OUT_RELEASE, OUT_REPEAT;
  logic       OUT_TICK;

  btn_debounce_repeat #(
    .TICK_DIV  (TD),
    .DEB_TICKS (DEB),
    .HOLD_TICKS(HOLD),
    .RPT_TICKS (RPT)
  ) dut (
    .IN_CLK     (IN_CLK),
    .IN_RSTN    (IN_RSTN),
    .IN_ENABLE  (IN_ENABLE),
    .IN_BTN     (IN_BTN),
    .OUT_LEVEL  (OUT_LEVEL),
    .OUT_PRESS  (OUT_PRESS),
    .OUT_RELEASE(OUT_RELEASE),
    .OUT_REPEAT (OUT_REPEAT),
    .OUT_TICK   (OUT_TICK)
  );

  initial IN_CLK = 1'b0;
  always #5 IN_CLK = ~IN_CLK;

  int ecnt = 0;
  always @(posedge IN_CLK) ecnt <= ecnt + 1;

  int total = 0;
  int bad   = 0;
  int base  = 0;
  int p_edge [5];
  int r_edge [5];
  int rpt0_cnt = 0;
  int rel0_cnt = 0;

  typedef struct {
    int         n;
    logic [4:0] btn;
    logic       en;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] rpt;
    logic       tck;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, req, ecnt - base);
    end
  endtask

  // Edge (relative to reset release) at which a level change driven just after edge e shows up
  function automatic int lvl_edge(input int e);
    int f;
    f = ((e + 3 + TD - 1) / TD) * TD;
    return f + (DEB - 1) * TD;
  endfunction

  function automatic logic rpt_due(input int c, input int p, input int r);
    if (p < 0 || c < p || (r >= 0 && c >= r)) return 1'b0;
    if (c == p) return 1'b1;
    if (c < p + HOLD * TD) return 1'b0;
    return ((c - p - HOLD * TD) % (RPT * TD)) == 0;
  endfunction

  task automatic step_chk();
    logic       en_b;
    logic [4:0] el, ep, er, erp;
    int         now;
    en_b = IN_ENABLE;
    @(posedge IN_CLK);
    #1;
    now = ecnt - base;
    for (int i = 0; i < 5; i++) begin
      el[i]  = p_edge[i] >= 0 && now >= p_edge[i] && (r_edge[i] < 0 || now < r_edge[i]);
      ep[i]  = en_b && now == p_edge[i];
      er[i]  = en_b && r_edge[i] >= 0 && now == r_edge[i];
      erp[i] = en_b && rpt_due(now, p_edge[i], r_edge[i]);
    end
    if (OUT_REPEAT[0]) rpt0_cnt++;
    if (OUT_RELEASE[0]) rel0_cnt++;
    chk("level", 32'(OUT_LEVEL), 32'(el));
    chk("press", 32'(OUT_PRESS), 32'(ep));
    chk("release", 32'(OUT_RELEASE), 32'(er));
    chk("repeat", 32'(OUT_REPEAT), 32'(erp));
    chk("tick", 32'(OUT_TICK), 32'((now % TD) == TD - 1));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_chk();
  endtask

  task automatic press(input logic [4:0] m);
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        IN_BTN[i] = 1'b1;
        p_edge[i] = lvl_edge(ecnt - base);
        r_edge[i] = -1;
      end
    end
  endtask

  task automatic release_btn(input logic [4:0] m);
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        IN_BTN[i] = 1'b0;
        r_edge[i] = lvl_edge(ecnt - base);
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " level"}, 32'(OUT_LEVEL), 32'd0);
    chk({name, " press"}, 32'(OUT_PRESS), 32'd0);
    chk({name, " release"}, 32'(OUT_RELEASE), 32'd0);
    chk({name, " repeat"}, 32'(OUT_REPEAT), 32'd0);
    chk({name, " tick"}, 32'(OUT_TICK), 32'd0);
  endtask

  initial begin
    // n, btn, en, lvl, prs, rel, rpt, tck -- checked after n edges, earlier edges must be quiet
    tbl[0]  = '{3, 5'h1F, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1};
    tbl[1]  = '{5, 5'h1F, 1'b1, 5'h1F, 5'h1F, 5'h00, 5'h1F, 1'b0};
    tbl[2]  = '{1, 5'h1F, 1'b1, 5'h1F, 5'h00, 5'h00, 5'h00, 1'b0};
    tbl[3]  = '{7, 5'h00, 1'b1, 5'h00, 5'h00, 5'h1F, 5'h00, 1'b0};
    tbl[4]  = '{3, 5'h00, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1};
    tbl[5]  = '{4, 5'h04, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1};
    tbl[6]  = '{8, 5'h00, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1};
    tbl[7]  = '{9, 5'h04, 1'b1, 5'h04, 5'h04, 5'h00, 5'h04, 1'b0};
    tbl[8]  = '{3, 5'h04, 1'b1, 5'h04, 5'h00, 5'h00, 5'h00, 1'b1};
    tbl[9]  = '{9, 5'h00, 1'b1, 5'h00, 5'h00, 5'h04, 5'h00, 1'b0};
    tbl[10] = '{1, 5'h00, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0};

    for (int i = 0; i < 5; i++) begin
      p_edge[i] = -1;
      r_edge[i] = -1;
    end

    // Reset with every button held
    IN_RSTN   = 1'b0;
    IN_ENABLE = 1'b1;
    IN_BTN    = 5'h1F;
    #2;
    chk_all_zero("rst");
    repeat (3) @(posedge IN_CLK);
    #1;
    chk_all_zero("rst held");
    IN_RSTN = 1'b1;
    base    = ecnt;

    // Reset release with buttons held, then glitch rejection on bit 2
    for (int r = 0; r < 11; r++) begin
      IN_BTN    = tbl[r].btn;
      IN_ENABLE = tbl[r].en;
      for (int k = 0; k < tbl[r].n - 1; k++) begin
        @(posedge IN_CLK);
        #1;
        chk("tbl quiet", 32'(OUT_PRESS | OUT_RELEASE | OUT_REPEAT), 32'd0);
      end
      @(posedge IN_CLK);
      #1;
      chk("tbl level", 32'(OUT_LEVEL), 32'(tbl[r].lvl));
      chk("tbl press", 32'(OUT_PRESS), 32'(tbl[r].prs));
      chk("tbl release", 32'(OUT_RELEASE), 32'(tbl[r].rel));
      chk("tbl repeat", 32'(OUT_REPEAT), 32'(tbl[r].rpt));
      chk("tbl tick", 32'(OUT_TICK), 32'(tbl[r].tck));
    end

    // Hold bit 0 long enough for 7 repeat pulses, then release
    rpt0_cnt = 0;
    rel0_cnt = 0;
    press(5'h01);
    run(64);
    release_btn(5'h01);
    run(12);
    chk("bit0 repeat count", 32'(rpt0_cnt), 32'd7);
    chk("bit0 release count", 32'(rel0_cnt), 32'd1);

    // Bits 1 and 3 together, bit 1 released early
    press(5'h0A);
    run(30);
    release_btn(5'h02);
    run(30);
    release_btn(5'h08);
    run(12);

    // Press while disabled, enable mid-hold
    IN_ENABLE = 1'b0;
    press(5'h10);
    run(40);
    IN_ENABLE = 1'b1;
    run(20);
    release_btn(5'h10);
    run(12);

    // Reset while bit 2 is repeating
    press(5'h04);
    run(32);
    IN_RSTN = 1'b0;
    #1;
    chk_all_zero("mid rst");
    repeat (2) @(posedge IN_CLK);
    #1;
    chk_all_zero("mid rst held");
    IN_RSTN = 1'b1;
    base    = ecnt;
    for (int i = 0; i < 5; i++) begin
      p_edge[i] = -1;
      r_edge[i] = -1;
    end
    p_edge[2] = lvl_edge(0);
    run(40);
    release_btn(5'h04);
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
